// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, state encoding and sign-extend helper for the MAC accumulator
package mac_pkg;

    localparam int IN_W_DEF  = 32;
    localparam int CNT_W_DEF = 8;
    localparam int ACC_W_DEF = 40;
    localparam int EXT_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Replicates bit from_w-1 of val across the upper bits of a full-width word.
    function automatic logic [EXT_MAX_W-1:0] sign_extend(input logic [EXT_MAX_W-1:0] val,
                                                         input int from_w);
        logic signed [EXT_MAX_W-1:0] tmp;
        tmp = $signed(val << (EXT_MAX_W - from_w));
        return $unsigned(tmp >>> (EXT_MAX_W - from_w));
    endfunction

endpackage

// File: rtl/acc_lane.sv
// rtl/acc_lane.sv - one signed accumulator lane with clear, enable and overflow detection
module acc_lane
    import mac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [IN_W-1:0]  i_din,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum;

    assign ext = ACC_W'(sign_extend(EXT_MAX_W'(i_din), IN_W));
    assign sum = acc_q + ext;

    // Operands agree in sign but the wrapped result does not.
    assign o_ovf = i_en && !i_clr
                   && (acc_q[ACC_W-1] == ext[ACC_W-1])
                   && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_sum = acc_q;

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - frames two signed MAC result lanes into per-frame sums with a result handshake
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_in1,
    input  logic [IN_W-1:0]  i_in2,
    output logic             o_in_ready,
    output logic             o_busy,
    output logic [ACC_W-1:0] o_acc1,
    output logic [ACC_W-1:0] o_acc2,
    output logic             o_ovf,
    output logic             o_valid,
    input  logic             i_ready
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             clr;
    logic             accept;
    logic             ovf1;
    logic             ovf2;

    assign accept = (state_q == ST_ACC) && i_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    len_d   = i_len;
                    ovf_d   = 1'b0;
                    // A zero-length frame yields an immediate all-zero result.
                    state_d = (i_len != '0) ? ST_ACC : ST_DONE;
                end
            end
            ST_ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | ovf1 | ovf2;
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    acc_lane #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_lane1 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (clr),
        .i_en  (accept),
        .i_din (i_in1),
        .o_sum (o_acc1),
        .o_ovf (ovf1)
    );

    acc_lane #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_lane2 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (clr),
        .i_en  (accept),
        .i_din (i_in2),
        .o_sum (o_acc2),
        .o_ovf (ovf2)
    );

    assign o_in_ready = (state_q == ST_ACC);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_valid    = (state_q == ST_DONE);
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized self-checking bench for mac_accumulator against a reference model
module tb_mac_accumulator;

    localparam int IN_W  = 32;
    localparam int CNT_W = 8;
    localparam int W_A   = 40;
    localparam int W_B   = 34;
    localparam int NPIN  = 8;

    localparam int S_ACC1_A  = 0;
    localparam int S_ACC2_A  = 1;
    localparam int S_OVF_A   = 2;
    localparam int S_VALID_A = 3;
    localparam int S_BUSY_A  = 4;
    localparam int S_INRDY_A = 5;
    localparam int S_ACC1_B  = 6;
    localparam int S_OVF_B   = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             valid;
    logic             ready;
    logic [CNT_W-1:0] len;
    logic [IN_W-1:0]  in1;
    logic [IN_W-1:0]  in2;
    logic             in_ready_a, busy_a, ovf_a, valid_a;
    logic             in_ready_b, busy_b, ovf_b, valid_b;
    logic [W_A-1:0]   acc1_a, acc2_a;
    logic [W_B-1:0]   acc1_b, acc2_b;

    initial forever #5 clk = ~clk;

    mac_accumulator #(.IN_W(IN_W), .CNT_W(CNT_W), .ACC_W(W_A)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .i_valid(valid),
        .i_in1(in1), .i_in2(in2), .o_in_ready(in_ready_a), .o_busy(busy_a),
        .o_acc1(acc1_a), .o_acc2(acc2_a), .o_ovf(ovf_a), .o_valid(valid_a), .i_ready(ready)
    );

    mac_accumulator #(.IN_W(IN_W), .CNT_W(CNT_W), .ACC_W(W_B)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .i_valid(valid),
        .i_in1(in1), .i_in2(in2), .o_in_ready(in_ready_b), .o_busy(busy_b),
        .o_acc1(acc1_b), .o_acc2(acc2_b), .o_ovf(ovf_b), .o_valid(valid_b), .i_ready(ready)
    );

    // Reference model: exact integer sums wrapped to each lane width, frame tracked as samples remaining.
    longint m_s1 [2];
    longint m_s2 [2];
    bit     m_ovf [2];
    int     m_rem;
    bit     m_pend;
    longint t1, t2;

    function automatic int lane_w(input int k);
        return (k == 0) ? W_A : W_B;
    endfunction

    function automatic longint sx(input logic [IN_W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint wrap(input longint v, input int w);
        longint span;
        longint r;
        span = 64'sd1 <<< w;
        r = v % span;
        if (r < 0) r += span;
        if (r >= span / 2) r -= span;
        return r;
    endfunction

    function automatic bit out_of_range(input longint v, input int w);
        longint lim;
        lim = 64'sd1 <<< (w - 1);
        return (v >= lim) || (v < -lim);
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_rem  = 0;
            m_pend = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_ovf[k] = 1'b0;
            end
        end else if (m_pend) begin
            if (ready) m_pend = 1'b0;
        end else if (m_rem != 0) begin
            if (valid) begin
                for (int k = 0; k < 2; k++) begin
                    t1 = m_s1[k] + sx(in1);
                    t2 = m_s2[k] + sx(in2);
                    if (out_of_range(t1, lane_w(k)) || out_of_range(t2, lane_w(k))) m_ovf[k] = 1'b1;
                    m_s1[k] = wrap(t1, lane_w(k));
                    m_s2[k] = wrap(t2, lane_w(k));
                end
                m_rem = m_rem - 1;
                if (m_rem == 0) m_pend = 1'b1;
            end
        end else if (start) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_ovf[k] = 1'b0;
            end
            m_rem  = int'(len);
            m_pend = (len == '0);
        end
    end

    // Hand-computed expectations posted by the stimulus, checked at the next falling edge.
    string  pin_name [NPIN];
    int     pin_sig  [NPIN];
    longint pin_exp  [NPIN];
    int     pin_cnt  = 0;
    int     pin_seq  = 0;
    int     stage_n  = 0;
    int     seen_seq = 0;
    int     n_checks = 0;
    int     n_fail   = 0;

    function automatic longint sig_val(input int s);
        case (s)
            S_ACC1_A:  return longint'($signed(acc1_a));
            S_ACC2_A:  return longint'($signed(acc2_a));
            S_OVF_A:   return longint'(ovf_a);
            S_VALID_A: return longint'(valid_a);
            S_BUSY_A:  return longint'(busy_a);
            S_INRDY_A: return longint'(in_ready_a);
            S_ACC1_B:  return longint'($signed(acc1_b));
            S_OVF_B:   return longint'(ovf_b);
            default:   return -1;
        endcase
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        chk("valid_a",    longint'(valid_a),    longint'(m_pend));
        chk("busy_a",     longint'(busy_a),     longint'(m_pend || m_rem != 0));
        chk("in_ready_a", longint'(in_ready_a), longint'(!m_pend && m_rem != 0));
        chk("acc1_a",     longint'($signed(acc1_a)), m_s1[0]);
        chk("acc2_a",     longint'($signed(acc2_a)), m_s2[0]);
        chk("ovf_a",      longint'(ovf_a),      longint'(m_ovf[0]));
        chk("valid_b",    longint'(valid_b),    longint'(m_pend));
        chk("busy_b",     longint'(busy_b),     longint'(m_pend || m_rem != 0));
        chk("in_ready_b", longint'(in_ready_b), longint'(!m_pend && m_rem != 0));
        chk("acc1_b",     longint'($signed(acc1_b)), m_s1[1]);
        chk("acc2_b",     longint'($signed(acc2_b)), m_s2[1]);
        chk("ovf_b",      longint'(ovf_b),      longint'(m_ovf[1]));
        if (pin_seq != seen_seq) begin
            for (int i = 0; i < pin_cnt; i++) chk(pin_name[i], sig_val(pin_sig[i]), pin_exp[i]);
            seen_seq = pin_seq;
        end
    end

    logic [IN_W-1:0] q1 [$];
    logic [IN_W-1:0] q2 [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_pin(input string nm, input int s, input longint e);
        if (stage_n < NPIN) begin
            pin_name[stage_n] = nm;
            pin_sig[stage_n]  = s;
            pin_exp[stage_n]  = e;
            stage_n++;
        end
    endtask

    task automatic commit();
        pin_cnt = stage_n;
        stage_n = 0;
        pin_seq++;
    endtask

    task automatic fill_const(input int n, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
        q1.delete(); q2.delete();
        for (int i = 0; i < n; i++) begin q1.push_back(a); q2.push_back(b); end
    endtask

    task automatic fill_rand(input int n);
        q1.delete(); q2.delete();
        for (int i = 0; i < n; i++) begin q1.push_back($urandom); q2.push_back($urandom); end
    endtask

    // gaps: 0 = every cycle, 1 = alternate cycles, 2 = random.
    task automatic send_frame(input int n, input int gaps, input int nsend);
        int  sent;
        int  guard;
        bit  took;
        sent  = 0;
        guard = 0;
        start = 1'b1;
        len   = CNT_W'(n);
        tick();
        start = 1'b0;
        while (sent < nsend && guard < 4000) begin
            in1   = q1[sent];
            in2   = q2[sent];
            valid = (gaps == 0) || (gaps == 1 && guard % 2 == 1)
                    || (gaps == 2 && $urandom_range(0, 1) == 1);
            start = ($urandom_range(0, 3) == 0);
            len   = CNT_W'($urandom);
            ready = ($urandom_range(0, 1) == 1);
            took  = valid && in_ready_a;
            tick();
            if (took) sent++;
            guard++;
        end
        valid = 1'b0;
        start = 1'b0;
        if (sent < nsend) add_pin("send_timeout_in_ready", S_INRDY_A, 1);
    endtask

    task automatic drain(input int hold);
        for (int i = 0; i < hold; i++) begin
            ready = 1'b0;
            start = ($urandom_range(0, 1) == 1);
            len   = CNT_W'($urandom);
            tick();
        end
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b0;
        add_pin("drain_valid_low", S_VALID_A, 0);
        add_pin("drain_idle", S_BUSY_A, 0);
        commit();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; ready = 1'b0;
        len = '0; in1 = '0; in2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        add_pin("rst_acc1", S_ACC1_A, 0);
        add_pin("rst_acc2", S_ACC2_A, 0);
        add_pin("rst_ovf", S_OVF_A, 0);
        add_pin("rst_valid", S_VALID_A, 0);
        add_pin("rst_busy", S_BUSY_A, 0);
        add_pin("rst_in_ready", S_INRDY_A, 0);
        commit();
        tick();

        q1 = '{32'd1, 32'd2, 32'd3, 32'd4};
        q2 = '{-32'sd1, -32'sd2, -32'sd3, -32'sd4};
        send_frame(4, 0, 4);
        add_pin("f4_valid", S_VALID_A, 1);
        add_pin("f4_acc1", S_ACC1_A, 10);
        add_pin("f4_acc2", S_ACC2_A, -10);
        add_pin("f4_ovf", S_OVF_A, 0);
        commit();
        drain(0);

        send_frame(4, 1, 4);
        add_pin("gap_acc1", S_ACC1_A, 10);
        add_pin("gap_acc2", S_ACC2_A, -10);
        commit();
        drain(5);

        fill_const(5, 32'h7FFF_FFFF, 32'h0000_0001);
        send_frame(5, 2, 5);
        add_pin("ovf34_flag", S_OVF_B, 1);
        add_pin("ovf34_acc1", S_ACC1_B, -64'sd6442450949);
        add_pin("ovf40_flag", S_OVF_A, 0);
        add_pin("ovf40_acc1", S_ACC1_A, 64'sd10737418235);
        commit();
        drain(2);

        fill_const(1, 32'd3, 32'd0);
        send_frame(1, 0, 1);
        add_pin("after_ovf_flag", S_OVF_B, 0);
        add_pin("after_ovf_acc1", S_ACC1_B, 3);
        commit();
        drain(1);

        fill_const(255, 32'h7FFF_FFFF, 32'h8000_0000);
        send_frame(255, 0, 255);
        add_pin("max_acc1", S_ACC1_A, 64'sd547608329985);
        add_pin("max_acc2", S_ACC2_A, -64'sd547608330240);
        add_pin("max_ovf", S_OVF_A, 0);
        add_pin("max_ovf34", S_OVF_B, 1);
        commit();
        drain(0);

        fill_rand(4);
        send_frame(4, 0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        add_pin("midrst_acc1", S_ACC1_A, 0);
        add_pin("midrst_acc2", S_ACC2_A, 0);
        add_pin("midrst_ovf", S_OVF_A, 0);
        add_pin("midrst_valid", S_VALID_A, 0);
        add_pin("midrst_busy", S_BUSY_A, 0);
        add_pin("midrst_in_ready", S_INRDY_A, 0);
        commit();
        tick();
        fill_const(1, 32'd7, 32'd0);
        send_frame(1, 0, 1);
        add_pin("post_rst_acc1", S_ACC1_A, 7);
        commit();
        drain(0);

        send_frame(0, 0, 0);
        add_pin("len0_valid", S_VALID_A, 1);
        add_pin("len0_acc1", S_ACC1_A, 0);
        add_pin("len0_acc2", S_ACC2_A, 0);
        add_pin("len0_ovf", S_OVF_A, 0);
        commit();
        drain(0);

        for (int f = 0; f < 24; f++) begin
            int n;
            n = $urandom_range(1, 12);
            fill_rand(n);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                valid = ($urandom_range(0, 1) == 1);
                in1   = $urandom;
                tick();
            end
            valid = 1'b0;
            send_frame(n, $urandom_range(0, 2), n);
            add_pin("rnd_valid", S_VALID_A, 1);
            commit();
            drain($urandom_range(0, 3));
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
